// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Bit timing follows i_baud_tick; a one-byte hold register allows gap-free back-to-back frames.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud_tick,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done,
  output logic [2:0]           o_state
);

  // Handshake: a byte transfers on any i_clk edge where i_tx_valid && o_tx_ready;
  // i_tx_data is sampled only on that edge, o_tx_ready never depends on i_tx_valid.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       PAR_INV   = (PARITY_ODD != 0);
  localparam logic       PAR_USE   = (PARITY_EN != 0);

  state_t                r_state;
  logic                  r_init;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_hold;
  logic                  r_hold_full;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_done;
  logic [3:0]            r_cnt;

  logic                  w_last_stop;
  logic                  w_xfer;

  assign w_last_stop = (r_state == S_STOP) && (r_cnt == LAST_STOP);
  // r_init keeps ready low until the first edge after reset is released.
  assign o_tx_ready  = r_init && ((r_state == S_IDLE) || (w_last_stop && !r_hold_full));
  assign w_xfer      = i_tx_valid && o_tx_ready;

  assign o_tx      = r_tx;
  assign o_tx_done = r_done;
  assign o_tx_busy = (r_state != S_IDLE);
  assign o_state   = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_init      <= 1'b0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_parity    <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_init <= 1'b1;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          // A tick coinciding with the transfer is deliberately not used.
          if (w_xfer) begin
            r_shift  <= i_tx_data;
            r_parity <= (^i_tx_data) ^ PAR_INV;
            r_state  <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (i_baud_tick) begin
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (i_baud_tick) begin
            r_tx    <= r_shift[0];
            r_cnt   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (i_baud_tick) begin
            if (r_cnt == LAST_DATA) begin
              r_cnt   <= '0;
              r_tx    <= PAR_USE ? r_parity : 1'b1;
              r_state <= PAR_USE ? S_PARITY : S_STOP;
            end else begin
              r_cnt   <= r_cnt + 4'd1;
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
            end
          end
        end
        S_PARITY: begin
          if (i_baud_tick) begin
            r_tx    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (i_baud_tick) begin
            if (r_cnt == LAST_STOP) begin
              r_done <= 1'b1;
              r_cnt  <= '0;
              if (r_hold_full) begin
                r_shift     <= r_hold;
                r_parity    <= (^r_hold) ^ PAR_INV;
                r_hold      <= '0;
                r_hold_full <= 1'b0;
                r_tx        <= 1'b0;
                r_state     <= S_START;
              end else if (w_xfer) begin
                // Byte arriving on the closing tick itself chains straight into a start bit.
                r_shift  <= i_tx_data;
                r_parity <= (^i_tx_data) ^ PAR_INV;
                r_tx     <= 1'b0;
                r_state  <= S_START;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else if (w_xfer) begin
            r_hold      <= i_tx_data;
            r_hold_full <= 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter variants share clock, reset, tick and data,
// each frame is compared bit-interval by bit-interval against a queue built from the frame rules.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       tick_hold;
  logic [8:0] tx_data;
  logic [3:0] valid;
  logic [3:0] w_tx, w_ready, w_busy, w_done;
  logic [2:0] w_state [4];

  int total = 0;
  int bad   = 0;
  int tcnt  = 0;

  int cfg_db [4] = '{8, 8, 8, 9};
  int cfg_pe [4] = '{0, 1, 1, 1};
  int cfg_po [4] = '{0, 0, 1, 0};
  int cfg_sb [4] = '{1, 1, 2, 2};

  logic [0:0] exp_q[$];

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_tx_data(tx_data[7:0]),
    .i_tx_valid(valid[0]), .o_tx_ready(w_ready[0]), .o_tx(w_tx[0]),
    .o_tx_busy(w_busy[0]), .o_tx_done(w_done[0]), .o_state(w_state[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_tx_data(tx_data[7:0]),
    .i_tx_valid(valid[1]), .o_tx_ready(w_ready[1]), .o_tx(w_tx[1]),
    .o_tx_busy(w_busy[1]), .o_tx_done(w_done[1]), .o_state(w_state[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_tx_data(tx_data[7:0]),
    .i_tx_valid(valid[2]), .o_tx_ready(w_ready[2]), .o_tx(w_tx[2]),
    .o_tx_busy(w_busy[2]), .o_tx_done(w_done[2]), .o_state(w_state[2]));
  uart_tx #(.DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_tx_data(tx_data),
    .i_tx_valid(valid[3]), .o_tx_ready(w_ready[3]), .o_tx(w_tx[3]),
    .o_tx_busy(w_busy[3]), .o_tx_done(w_done[3]), .o_state(w_state[3]));

  // clock / reset-independent tick source: every 4th clk, or every clk when tick_hold is set
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_hold) begin
        tick = 1'b1;
      end else begin
        tcnt = (tcnt >= 3) ? 0 : tcnt + 1;
        tick = (tcnt == 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop 1s.
  task automatic build_exp(input int idx, input logic [8:0] data);
    logic p;
    exp_q.delete();
    exp_q.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < cfg_db[idx]; i++) begin
      exp_q.push_back(data[i]);
      p = p ^ data[i];
    end
    if (cfg_pe[idx] != 0) exp_q.push_back(p ^ (cfg_po[idx] != 0));
    for (int i = 0; i < cfg_sb[idx]; i++) exp_q.push_back(1'b1);
  endtask

  task automatic handshake(input int idx, input logic [8:0] data, input logic want_tick, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(w_ready[idx] === 1'b1 && tick === want_tick) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_hs_ready"}, {31'b0, w_ready[idx]}, 32'd1);
    tx_data    = data;
    valid[idx] = 1'b1;
    @(posedge clk);
    #2;
    valid[idx] = 1'b0;
    tx_data    = 9'($urandom);
  endtask

  task automatic wait_align(input int idx, input string tag);
    bit ok;
    int n;
    ok = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
      if (w_tx[idx] !== 1'b1 || w_busy[idx] !== 1'b1) ok = 1'b0;
    end while (tick !== 1'b1 && n < 40);
    chk({tag, "_align"}, {30'b0, ok, tick}, 32'd3);
  endtask

  // Checks lim intervals of the frame; a full frame also checks the tx_done pulse.
  task automatic frame(input int idx, input logic [8:0] data, input bit has_next,
                       input logic [8:0] nxt, input string tag, input int lim);
    bit ok;
    bit sent;
    int n;
    int dones;
    int nb;
    build_exp(idx, data);
    nb    = (lim < exp_q.size()) ? lim : exp_q.size();
    dones = 0;
    sent  = 1'b0;
    for (int k = 0; k < nb; k++) begin
      ok = 1'b1;
      n  = 0;
      do begin
        @(negedge clk);
        n++;
        if (w_tx[idx] !== exp_q[k]) ok = 1'b0;
        if (w_done[idx] === 1'b1) dones++;
        if (has_next && k == exp_q.size() - 1 && !sent && w_ready[idx] === 1'b1 && tick === 1'b0) begin
          tx_data    = nxt;
          valid[idx] = 1'b1;
          sent       = 1'b1;
        end else if (sent) begin
          valid[idx] = 1'b0;
          tx_data    = 9'($urandom);
        end
      end while (tick !== 1'b1 && n < 40);
      chk($sformatf("%s_bit%0d", tag, k), {30'b0, ok, tick}, 32'd3);
    end
    valid[idx] = 1'b0;
    chk({tag, "_no_early_done"}, dones, 0);
    if (nb == exp_q.size()) begin
      if (has_next) chk({tag, "_next_sent"}, {31'b0, sent}, 32'd1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'b0, w_done[idx]}, 32'd1);
      chk({tag, "_after_tx"}, {31'b0, w_tx[idx]}, has_next ? 32'd0 : 32'd1);
      if (!has_next) begin
        @(negedge clk);
        chk({tag, "_done_clear"}, {31'b0, w_done[idx]}, 32'd0);
        chk({tag, "_idle_ready"}, {30'b0, w_ready[idx], w_busy[idx]}, 32'd2);
      end
    end
  endtask

  task automatic one_frame(input int idx, input logic [8:0] data, input logic want_tick, input string tag);
    handshake(idx, data, want_tick, tag);
    wait_align(idx, tag);
    frame(idx, data, 1'b0, 9'd0, tag, 99);
  endtask

  initial begin
    logic [8:0] rd;
    int seen_done;
    rst       = 1'b1;
    tick_hold = 1'b0;
    valid     = 4'b0;
    tx_data   = 9'd0;

    // reset behaviour
    repeat (2) @(negedge clk);
    chk("rst_tx", {28'b0, w_tx}, 32'hF);
    chk("rst_busy_done", {24'b0, w_busy, w_done}, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_ready", {28'b0, w_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_ready_low", {28'b0, w_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("rel_ready_high", {28'b0, w_ready}, 32'hF);
    chk("rel_state", {23'b0, w_state[0], w_state[1], w_state[3]}, 32'h0);

    // directed frames
    one_frame(0, 9'h0A5, 1'b0, "a5_8n1");
    one_frame(1, 9'h007, 1'b0, "p07_even");
    one_frame(2, 9'h007, 1'b0, "p07_odd_2stop");

    // back-to-back through the hold register
    handshake(0, 9'h055, 1'b0, "b2b");
    wait_align(0, "b2b");
    frame(0, 9'h055, 1'b1, 9'h00F, "b2b_55", 99);
    frame(0, 9'h00F, 1'b0, 9'h000, "b2b_0f", 99);

    // transfer coinciding with a tick, two stop bits
    one_frame(2, 9'h0C3, 1'b1, "coll_2stop");

    // randomized frames on every variant
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        rd = 9'($urandom_range(0, 511));
        one_frame(i, rd, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_u%0d", r, i));
      end
    end

    // tick held high: one bit per clk
    tick_hold = 1'b1;
    one_frame(3, 9'($urandom_range(0, 511)), 1'b1, "hold9");
    one_frame(0, 9'($urandom_range(0, 255)), 1'b1, "hold8");
    tick_hold = 1'b0;

    // reset during data bit 3
    handshake(0, 9'h0FF, 1'b0, "mrst");
    wait_align(0, "mrst");
    frame(0, 9'h0FF, 1'b0, 9'd0, "mrst_ff", 4);
    @(negedge clk);
    chk("mrst_pre_tx", {31'b0, w_tx[0]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_tx_now", {31'b0, w_tx[0]}, 32'd1);
    chk("mrst_busy_done", {30'b0, w_busy[0], w_done[0]}, 32'd0);
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (w_done[0] === 1'b1) seen_done++;
    end
    rst = 1'b0;
    #1;
    chk("mrst_ready_low", {31'b0, w_ready[0]}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (w_done[0] === 1'b1) seen_done++;
    end
    chk("mrst_no_done", seen_done, 0);
    chk("mrst_ready", {31'b0, w_ready[0]}, 32'd1);
    one_frame(0, 9'h000, 1'b0, "mrst_00");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
